// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding decode.
// Keeps the program counter and issues reads to instruction memory with at
// most one request outstanding. The fetched word, its PC and its
// fall-through PC go to decode through an output register. A one-entry skid
// buffer holds a response that arrives while decode is stalled. A flush
// redirects fetch and drops any response still in flight.
// Optional feature macro: BTFN_PREDICT_EN. When it is defined, a static
// backward-taken / forward-not-taken predictor picks the next fetch address.

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic [31:0] pc1,
   output logic [31:0] notbranchD
);

   typedef enum logic [1:0] {
      ISSUE = 2'd0,   // ready to issue from pc_q once the buffer is empty
      WAIT  = 2'd1,   // one request outstanding
      DROP  = 2'd2    // one stale request outstanding; discard its response
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q;        // next address to request from ISSUE
   logic [31:0] req_pc;      // address of the outstanding request
   logic [31:0] buf_ir;
   logic [31:0] buf_pc;
   logic        buf_valid;
   logic [31:0] nxt;         // address that follows the current response

   logic        resp;        // live response in WAIT, not flushed
   logic        take;        // response goes straight to the output register
   logic        park;        // response goes into the skid buffer (stalled)
   logic        issue_a;     // issue from pc_q while in ISSUE
   logic        issue_b;     // back-to-back issue while a response is taken

`ifdef BTFN_PREDICT_EN
   logic [31:0] j_imm;
   logic [31:0] b_imm;

   // Predecode the response word: take backward branches and JAL, fall through otherwise
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      j_imm = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
               imem_rdata[30:21], 1'b0};
      b_imm = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
               imem_rdata[11:8], 1'b0};
      nxt   = req_pc + 32'd4;
      if (imem_rdata[6:0] == 7'b1101111) begin
         nxt = req_pc + j_imm;
      end else if (imem_rdata[6:0] == 7'b1100011 && imem_rdata[31]) begin
         nxt = req_pc + b_imm;
      end
   end
`else
   // Sequential fetch: the next address is always the fall-through
   assign nxt = req_pc + 32'd4;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (!rst_n) begin
         state <= ISSUE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: flush overrides everything, else follow the request/response handshake
   always_comb begin
      state_nxt = state;
      if (flush) begin
         // An unanswered request is still in flight: its response must be dropped
         if ((state == WAIT || state == DROP) && !imem_valid) begin
            state_nxt = DROP;
         end else begin
            state_nxt = ISSUE;
         end
      end else begin
         unique case (state)
            ISSUE:   if (issue_a)    state_nxt = WAIT;
            WAIT:    if (imem_valid) state_nxt = issue_b ? WAIT : ISSUE;
            DROP:    if (imem_valid) state_nxt = ISSUE;
            default: state_nxt = ISSUE;
         endcase
      end
   end

   // FSM outputs: response classification and the memory request
   always_comb begin
      resp      = (state == WAIT) && imem_valid && !flush;
      take      = resp && !stall;
      park      = resp && stall;
      issue_a   = (state == ISSUE) && !buf_valid && !flush;
      issue_b   = take && !buf_valid;
      // Held low during reset so memory sees no request until fetch starts
      imem_req  = rst_n && (issue_a || issue_b);
      imem_addr = issue_b ? nxt : pc_q;
   end

   // Fetch address bookkeeping: redirect on flush, advance when a response parks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         req_pc <= RESET_PC;
      end else begin
         if (flush) begin
            pc_q <= redirect_pc;
         end else if (park) begin
            pc_q <= nxt;
         end
         if (imem_req) begin
            req_pc <= imem_addr;
         end
      end
   end

   // Skid buffer occupancy: fill on a stalled response, drain when decode accepts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= 1'b0;
      end else if (flush) begin
         buf_valid <= 1'b0;
      end else if (park) begin
         buf_valid <= 1'b1;
      end else if (!stall) begin
         buf_valid <= 1'b0;
      end
   end

   // Skid buffer payload: captured alongside buf_valid
   always_ff @(posedge clk) begin
      // NOTE: the payload is not reset; it is only ever read while buf_valid
      // is set, and buf_valid is reset.
      if (park) begin
         buf_ir <= imem_rdata;
         buf_pc <= req_pc;
      end
   end

   // Decode-facing output register: flush bubbles, stall holds, else buffer/response/bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir         <= NOP_INSN;
         pc1        <= '0;
         notbranchD <= '0;
      end else if (flush) begin
         ir <= NOP_INSN;
      end else if (!stall) begin
         if (buf_valid) begin
            ir         <= buf_ir;
            pc1        <= buf_pc;
            notbranchD <= buf_pc + 32'd4;
         end else if (take) begin
            ir         <= imem_rdata;
            pc1        <= req_pc;
            notbranchD <= req_pc + 32'd4;
         end else begin
            ir <= NOP_INSN;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage.
// A behavioural instruction memory with per-request latency answers the
// DUT's requests. A per-cycle vector table covers reset release,
// streaming, stall buffering, flush/stall interaction, address wrap and
// flush during an in-flight request. A scoreboarded random-stall stream
// follows, plus a predictor sequence when BTFN_PREDICT_EN is defined.

module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] ir;
   logic [31:0] pc1;
   logic [31:0] notbranchD;

   fetch_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .flush      (flush),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .ir         (ir),
      .pc1        (pc1),
      .notbranchD (notbranchD)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      int          lat;
      logic        st;
      logic        fl;
      logic [31:0] rd;
      logic        ereq;
      logic [31:0] eaddr;
      logic [31:0] eir;
      logic [31:0] epc;
      logic [31:0] enb;
   } vec_t;

   pend_t       pend[$];
   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   int          cyc = 0;
   int          lat = 1;
   int          n_checks = 0;
   int          n_err = 0;
   logic        obs_req;
   logic [31:0] obs_addr;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_addr = '0;
   logic [31:0] ovr_word = '0;

   // Memory contents: an addi whose fields depend on the address; never equals NOP here
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] idx;
      logic [11:0] imm;
      logic [4:0]  rd;
      if (ovr_en && a == ovr_addr) return ovr_word;
      idx = a >> 2;
      imm = idx[11:0] + 12'd1;
      rd  = idx[4:0] + 5'd1;
      return {imm, a[31:27], 3'b000, rd, 7'h13};
   endfunction

   function automatic vec_t mk(input int l, input logic s, input logic f,
                               input logic [31:0] r, input logic q,
                               input logic [31:0] a, input logic [31:0] i_w,
                               input logic [31:0] p, input logic [31:0] n);
      vec_t v;
      v.lat = l; v.st = s; v.fl = f; v.rd = r; v.ereq = q;
      v.eaddr = a; v.eir = i_w; v.epc = p; v.enb = n;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs and memory response, observe request, advance edge
   task automatic step(input logic st, input logic fl, input logic [31:0] rd);
      pend_t p;
      stall = st;
      flush = fl;
      redirect_pc = rd;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_valid = 1'b1;
         imem_rdata = mem_word(pend[0].addr);
      end else begin
         imem_valid = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
      end
      #1;
      obs_req  = imem_req;
      obs_addr = imem_addr;
      if (imem_valid) pend.delete(0);
      if (imem_req) begin
         p.addr = imem_addr;
         p.due  = cyc + lat;
         pend.push_back(p);
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // Idle cycles until the DUT requests, bounded; then check the address
   task automatic run_until_req(input string name, input logic [31:0] exp);
      int n;
      n = 0;
      do begin
         step(1'b0, 1'b0, '0);
         n++;
      end while (!obs_req && n < 10);
      check({name, " req"}, {31'b0, obs_req}, 32'd1);
      check({name, " addr"}, obs_addr, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          delivered;
      logic        st;
      logic [31:0] e;

      // ---- reset values ----
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset ir", ir, NOP);
      check("reset pc1", pc1, 32'h0);
      check("reset notbranchD", notbranchD, 32'h0);
      check("reset imem_req", {31'b0, imem_req}, 32'd0);
      rst_n = 1'b1;

      // ---- per-cycle vectors: lat, stall, flush, redirect, req, addr, ir, pc1, nb ----
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,  NOP,            32'h0,  32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h4,  mem_word(32'h0), 32'h0,  32'h4));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h8,  mem_word(32'h4), 32'h4,  32'h8));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'hC,  mem_word(32'h8), 32'h8,  32'hC));
      vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,  mem_word(32'h8), 32'h8,  32'hC));
      vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,  mem_word(32'h8), 32'h8,  32'hC));
      vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,  mem_word(32'h8), 32'h8,  32'hC));
      vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,  mem_word(32'hC), 32'hC,  32'h10));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h10, NOP,             32'hC,  32'h10));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h14, mem_word(32'h10), 32'h10, 32'h14));
      vecs.push_back(mk(1, 1, 1, 32'h200, 0, 32'h0, NOP,        32'h10, 32'h14));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h200, NOP,            32'h10, 32'h14));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h204, mem_word(32'h200), 32'h200, 32'h204));
      vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, NOP,  32'h200, 32'h204));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'hFFFF_FFFC, NOP,      32'h200, 32'h204));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h4,  mem_word(32'h0), 32'h0,  32'h4));
      vecs.push_back(mk(3, 0, 0, 0, 1, 32'h8,  mem_word(32'h4), 32'h4,  32'h8));
      vecs.push_back(mk(3, 0, 0, 0, 0, 32'h0,  NOP,             32'h4,  32'h8));
      vecs.push_back(mk(3, 0, 1, 32'h100, 0, 32'h0, NOP,        32'h4,  32'h8));
      vecs.push_back(mk(3, 0, 0, 0, 0, 32'h0,  NOP,             32'h4,  32'h8));
      vecs.push_back(mk(3, 0, 0, 0, 1, 32'h100, NOP,            32'h4,  32'h8));
      vecs.push_back(mk(3, 0, 0, 0, 0, 32'h0,  NOP,             32'h4,  32'h8));
      vecs.push_back(mk(3, 0, 0, 0, 0, 32'h0,  NOP,             32'h4,  32'h8));
      vecs.push_back(mk(3, 0, 0, 0, 1, 32'h104, mem_word(32'h100), 32'h100, 32'h104));
      vecs.push_back(mk(3, 0, 1, 32'h40, 0, 32'h0, NOP,         32'h100, 32'h104));
      vecs.push_back(mk(3, 0, 1, 32'h80, 0, 32'h0, NOP,         32'h100, 32'h104));
      vecs.push_back(mk(3, 0, 0, 0, 0, 32'h0,  NOP,             32'h100, 32'h104));
      vecs.push_back(mk(3, 0, 0, 0, 1, 32'h80, NOP,             32'h100, 32'h104));

      for (int i = 0; i < vecs.size(); i++) begin
         lat = vecs[i].lat;
         step(vecs[i].st, vecs[i].fl, vecs[i].rd);
         check($sformatf("v%0d imem_req", i), {31'b0, obs_req}, {31'b0, vecs[i].ereq});
         if (vecs[i].ereq) check($sformatf("v%0d imem_addr", i), obs_addr, vecs[i].eaddr);
         check($sformatf("v%0d ir", i), ir, vecs[i].eir);
         check($sformatf("v%0d pc1", i), pc1, vecs[i].epc);
         check($sformatf("v%0d notbranchD", i), notbranchD, vecs[i].enb);
      end

      // ---- scoreboarded stream from 0x80 with random stalls and latency ----
      for (int k = 0; k < 200; k++) exp_q.push_back(32'h80 + 32'(4 * k));
      delivered = 0;
      for (int i = 0; i < 170; i++) begin
         lat = $urandom_range(1, 3);
         st  = (i < 150) && ($urandom_range(0, 3) == 0);
         step(st, 1'b0, '0);
         if (!st && ir !== NOP) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL stream overflow: got pc1 %h expected no further delivery", pc1);
            end else begin
               e = exp_q.pop_front();
               check("stream pc1", pc1, e);
               check("stream ir", ir, mem_word(e));
               check("stream notbranchD", notbranchD, e + 32'd4);
               delivered++;
            end
         end
      end
      check("stream deliveries >= 20", {31'b0, (delivered >= 20)}, 32'd1);

`ifdef BTFN_PREDICT_EN
      // ---- predictor: backward beq taken, forward bne not taken ----
      lat = 1;
      ovr_en = 1'b1;
      ovr_addr = 32'h20;
      ovr_word = 32'hFE00_08E3;   // beq x0,x0,-16
      step(1'b0, 1'b1, 32'h20);
      run_until_req("btfn beq fetch", 32'h20);
      step(1'b0, 1'b0, '0);
      check("btfn beq next req", {31'b0, obs_req}, 32'd1);
      check("btfn beq next addr", obs_addr, 32'h10);
      check("btfn beq pc1", pc1, 32'h20);
      check("btfn beq notbranchD", notbranchD, 32'h24);
      ovr_word = 32'h0000_1463;   // bne x0,x0,+8
      step(1'b0, 1'b1, 32'h20);
      run_until_req("btfn bne fetch", 32'h20);
      step(1'b0, 1'b0, '0);
      check("btfn bne next addr", obs_addr, 32'h24);
      check("btfn bne notbranchD", notbranchD, 32'h24);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipeline, directly upstream of the decode stage. Holds the program counter and issues one-outstanding-request reads to instruction memory. Delivers the fetched instruction word, its PC and its fall-through PC (`ir`, `pc1`, `notbranchD`) to decode, and inserts NOP bubbles whenever no instruction is ready. Honours the same `flush` and `stall` controls that drive decode, and redirects to the branch target on flush.

## Interface
- `RESET_PC`, 32'h0000_0000, address fetched first after reset.
- `NOP_INSN`, 32'h0000_0013, bubble word (`addi x0,x0,0`).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  decode cannot accept; hold `ir`/`pc1`/`notbranchD`.
- `flush`  in  1  discard fetched/in-flight work; redirect to `redirect_pc`.
- `redirect_pc`  in  32  new fetch address, sampled when `flush`=1.
- `imem_req`  out  1  read request strobe, one cycle per request, always accepted.
- `imem_addr`  out  32  request address, valid with `imem_req`.
- `imem_valid`  in  1  response strobe; ≥1 cycle after its request, in order.
- `imem_rdata`  in  32  instruction word, valid with `imem_valid`.
- `ir`  out  32  instruction to decode.
- `pc1`  out  32  PC of `ir`.
- `notbranchD`  out  32  `pc1`+4.

## Operation
- Registers: `pc_q` (next address to request), `req_pc` (address of outstanding request), 1-entry skid buffer (`buf_ir`, `buf_pc`, `buf_valid`), `state` ∈ {ISSUE, WAIT, DROP}.
- `nxt` = `req_pc`+4, wrapping mod 2^32; with `BTFN_PREDICT_EN`, `nxt` is the predicted target instead (see Configuration).
- Request issue occurs in either of two cases:
  - `state`=ISSUE, `buf_valid`=0, `flush`=0. Sets `imem_addr`=`pc_q`.
  - `state`=WAIT, `imem_valid`=1, `stall`=0, `flush`=0, `buf_valid`=0. This is a back-to-back issue with `imem_addr`=`nxt`, combinational from the response.
- On issue:
  - `req_pc` ← `imem_addr`.
  - `state` → WAIT.
- Response in WAIT, no flush:
  - With `stall`=0: `ir` ← `imem_rdata`, `pc1` ← `req_pc`, `notbranchD` ← `req_pc`+4.
  - With `stall`=1: the response goes into the buffer, `buf_valid` ← 1, `pc_q` ← `nxt`, `state` → ISSUE, and no request is issued.
- Output register update when `stall`=0 and `flush`=0, in priority order:
  - buffer contents if `buf_valid`; this clears `buf_valid`;
  - else the response if taken this cycle;
  - else `ir` ← `NOP_INSN`, with `pc1`/`notbranchD` unchanged.
- When `stall`=1: outputs hold; the buffer holds.
- `flush` has priority over `stall` and over any response:
  - `ir` ← `NOP_INSN`; `pc1`/`notbranchD` hold.
  - `buf_valid` ← 0; `pc_q` ← `redirect_pc`; no request is issued that cycle.
  - `state` → DROP if in WAIT and `imem_valid`=0; otherwise → ISSUE, discarding any same-cycle response.
- DROP:
  - No request is issued.
  - The next `imem_valid` is discarded and `state` → ISSUE.
  - A flush while in DROP updates `pc_q` and stays in DROP.

## Timing
- Reset values while `rst_n`=0:
  - `ir`=`NOP_INSN`, `pc1`=0, `notbranchD`=0, `imem_req`=0.
  - `pc_q`=`RESET_PC`, `buf_valid`=0, `state`=ISSUE.
- First `imem_req` occurs in the first cycle after `rst_n` rises.
- Reset mid-request: the in-flight response is ignored, because after reset the block expects no response until its first issue.
- Fetch-to-output latency: memory latency + 1 cycle (output register).
- With 1-cycle memory and no stall, throughput is one instruction per cycle.
- Flush-to-first-redirected-request latency:
  - 1 cycle if no request is in flight;
  - otherwise the cycle after the dropped response.
- Decode sees the first redirected instruction at the earliest 2 cycles after the request (1-cycle memory).
- `stall` and `flush` in the same cycle: flush wins.
- `imem_valid` outside WAIT/DROP is a protocol error and is ignored.

## Configuration
- `BTFN_PREDICT_EN` defined: static backward-taken/forward-not-taken prediction, by predecode of the response word.
  - JAL (opcode 1101111): `nxt` = `req_pc` + J-immediate.
  - B-type (opcode 1100011) with `imem_rdata[31]`=1: `nxt` = `req_pc` + B-immediate.
  - All others, including JALR: `req_pc`+4.
  - `notbranchD` is always `req_pc`+4, so execute can recover via flush.
- `BTFN_PREDICT_EN` undefined: `nxt` = `req_pc`+4 always; no predecode logic.

## Test plan
- Reset release, 1-cycle memory returning words 0x00100093, 0x00200113, … → requests at 0x0, 0x4, 0x8 on consecutive cycles; `ir`/`pc1`/`notbranchD` = 0x00100093/0x0/0x4, then 0x00200113/0x4/0x8, one per cycle.
- `stall` held 3 cycles while a response arrives → outputs frozen, response buffered, no `imem_req`. After release, the buffered word appears with the correct `pc1`, then fetch resumes at `pc1`+4.
- `flush` with `redirect_pc`=0x100 while a 3-cycle-latency response is outstanding → the stale response is dropped, `ir`=NOP, next `imem_req` has `imem_addr`=0x100, and the next delivered `pc1`=0x100.
- `flush` and `stall` in the same cycle with a response present → `ir`=NOP, buffer empty, next address = `redirect_pc`.
- `req_pc`=0xFFFF_FFFC fall-through → next address 0x0, `notbranchD`=0x0.
- With `BTFN_PREDICT_EN`: `beq` at 0x20 with offset −16 → next request 0x10, `notbranchD`=0x24. A forward `bne` → next request 0x24.
